// File: rtl/fsm_job_arbiter_pkg.sv
// fsm_arb_pkg: shared types and constants for the job arbiter.
// Holds the arbiter state encoding, the engine state codes seen on
// eng_state, and the completion status codes driven on cpl_status.
package fsm_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_HOLD    = 3'd3,
    ST_RELEASE = 3'd4,
    ST_DRAIN   = 3'd5
  } arb_state_e;

  localparam logic [1:0] ENG_IDLE = 2'b00;
  localparam logic [1:0] ENG_RUN  = 2'b01;
  localparam logic [1:0] ENG_DONE = 2'b10;
  localparam logic [1:0] ENG_ACKW = 2'b11;

  localparam logic [1:0] CPL_DONE   = 2'b01;
  localparam logic [1:0] CPL_ACK    = 2'b10;
  localparam logic [1:0] CPL_FORCED = 2'b11;

endpackage

// File: rtl/fsm_job_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector.
// Returns the first set request found scanning ptr+1, ptr+2, ... mod N_REQ,
// so the requester at ptr (most recently served) has the lowest priority.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IW    = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic             valid,
  output logic [IW-1:0]    idx
);

  logic [2*N_REQ-1:0] dbl_s;
  logic [IW:0]        shamt_s;
  logic [N_REQ-1:0]   rot_s;
  logic [IW-1:0]      off_s;
  logic [IW:0]        sum_s;

  // rot_s[j] is req[(ptr + 1 + j) mod N_REQ]
  assign dbl_s   = {req, req};
  assign shamt_s = {1'b0, ptr} + {{IW{1'b0}}, 1'b1};
  assign rot_s   = N_REQ'(dbl_s >> shamt_s);
  assign valid   = |req;

  // Lowest set bit of the rotated vector is the nearest requester after ptr
  always_comb begin
    off_s = '0;
    for (int j = N_REQ - 1; j >= 0; j--) begin
      off_s = rot_s[j] ? IW'(j) : off_s;
    end
  end

  // Undo the rotation: idx = (ptr + 1 + off) mod N_REQ
  always_comb begin
    sum_s = {1'b0, ptr} + {1'b0, off_s} + {{IW{1'b0}}, 1'b1};
    if (sum_s >= (IW+1)'(N_REQ)) begin
      idx = IW'(sum_s - (IW+1)'(N_REQ));
    end else begin
      idx = sum_s[IW-1:0];
    end
  end

endmodule

// File: rtl/fsm_job_arbiter.sv
// fsm_job_arbiter: round-robin arbiter/sequencer for one shared 4-state
// job engine. Grants one requester, strobes eng_start, follows eng_state
// to classify the outcome (done-path or ack-path), releases the engine
// with eng_init, and reports a one-cycle completion.
// All outputs are registered; eng_start follows gnt by one cycle.
// Optional build macro FSM_ARB_TIMEOUT_EN: bounds the HOLD wait to
// TIMEOUT cycles, then forces a release (err pulse, cpl_status 11).
module fsm_job_arbiter
  import fsm_arb_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 15,
  localparam int IW     = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  input  logic [1:0]       eng_state,
  input  logic             eng_ack,
  output logic             eng_start,
  output logic             eng_init,
  output logic             cpl,
  output logic [IW-1:0]    cpl_id,
  output logic [1:0]       cpl_status,
  output logic             busy,
  output logic             err
);

  arb_state_e       state_r, next_s;
  logic [IW-1:0]    ptr_r, w_r;
  logic [N_REQ-1:0] gnt_r;
  logic             eng_start_r, eng_init_r, cpl_r, busy_r, forced_r;
  logic [IW-1:0]    cpl_id_r;
  logic [1:0]       cpl_status_r;
  logic             pick_valid_s;
  logic [IW-1:0]    pick_idx_s;
  logic             grant_s, finish_s, tmo_fire_s, tmo_hit_s;
  logic [1:0]       cpl_st_s;

  rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
    .req   (req),
    .ptr   (ptr_r),
    .valid (pick_valid_s),
    .idx   (pick_idx_s)
  );

  // Next-state logic plus the grant/finish/timeout events it decides
  always_comb begin
    next_s     = state_r;
    grant_s    = 1'b0;
    finish_s   = 1'b0;
    tmo_fire_s = 1'b0;
    cpl_st_s   = CPL_DONE;
    case (state_r)
      ST_IDLE: begin
        if (pick_valid_s && (eng_state == ENG_IDLE)) begin
          next_s  = ST_START;
          grant_s = 1'b1;
        end else begin
          next_s = ST_IDLE;
        end
      end
      ST_START: next_s = ST_WAIT;
      ST_WAIT: begin
        if (eng_state == ENG_DONE) begin
          next_s = ST_DRAIN;
        end else if ((eng_state == ENG_ACKW) || eng_ack) begin
          next_s = ST_HOLD;
        end else begin
          next_s = ST_WAIT;
        end
      end
      ST_DRAIN: begin
        if (eng_state == ENG_IDLE) begin
          next_s   = ST_IDLE;
          finish_s = 1'b1;
          cpl_st_s = CPL_DONE;
        end else begin
          next_s = ST_DRAIN;
        end
      end
      ST_HOLD: begin
        // A requester dropping its own req wins over a same-cycle timeout
        if (!req[w_r]) begin
          next_s = ST_RELEASE;
        end else if (tmo_hit_s) begin
          next_s     = ST_RELEASE;
          tmo_fire_s = 1'b1;
        end else begin
          next_s = ST_HOLD;
        end
      end
      ST_RELEASE: begin
        if (eng_state == ENG_IDLE) begin
          next_s   = ST_IDLE;
          finish_s = 1'b1;
          cpl_st_s = forced_r ? CPL_FORCED : CPL_ACK;
        end else begin
          next_s = ST_RELEASE;
        end
      end
      default: next_s = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= next_s;
  end

  // Job bookkeeping: winner, round-robin pointer, forced-release flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_r      <= '0;
      ptr_r    <= IW'(N_REQ - 1);
      forced_r <= 1'b0;
    end else begin
      w_r      <= grant_s ? pick_idx_s : w_r;
      ptr_r    <= finish_s ? w_r : ptr_r;
      forced_r <= tmo_fire_s ? 1'b1 : (grant_s ? 1'b0 : forced_r);
    end
  end

  // Registered outputs, derived from the decided transition
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_r        <= '0;
      eng_start_r  <= 1'b0;
      eng_init_r   <= 1'b0;
      cpl_r        <= 1'b0;
      cpl_id_r     <= '0;
      cpl_status_r <= 2'b00;
      busy_r       <= 1'b0;
    end else begin
      if (grant_s)       gnt_r <= {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx_s;
      else if (finish_s) gnt_r <= '0;
      else               gnt_r <= gnt_r;
      eng_start_r  <= (state_r == ST_START);
      eng_init_r   <= (next_s == ST_RELEASE);
      cpl_r        <= finish_s;
      cpl_id_r     <= finish_s ? w_r : '0;
      cpl_status_r <= finish_s ? cpl_st_s : 2'b00;
      busy_r       <= (next_s != ST_IDLE);
    end
  end

`ifdef FSM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] tmo_cnt_r;
  logic          err_r;

  assign tmo_hit_s = (tmo_cnt_r == CW'(TIMEOUT));
  assign err       = err_r;

  // HOLD cycle counter, restarted on every entry into HOLD
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt_r <= '0;
    end else if ((state_r != ST_HOLD) && (next_s == ST_HOLD)) begin
      tmo_cnt_r <= '0;
    end else if ((state_r == ST_HOLD) && (next_s == ST_HOLD)) begin
      tmo_cnt_r <= tmo_cnt_r + CW'(1);
    end else begin
      tmo_cnt_r <= tmo_cnt_r;
    end
  end

  // One-cycle err pulse when HOLD is abandoned by timeout
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_r <= 1'b0;
    else     err_r <= tmo_fire_s;
  end
`else
  assign tmo_hit_s = 1'b0;
  assign err       = 1'b0;
`endif

  assign gnt        = gnt_r;
  assign eng_start  = eng_start_r;
  assign eng_init   = eng_init_r;
  assign cpl        = cpl_r;
  assign cpl_id     = cpl_id_r;
  assign cpl_status = cpl_status_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_fsm_job_arbiter.sv
// Directed bench for fsm_job_arbiter with a registered engine model and
// grant/completion scoreboards. Build with FSM_ARB_TIMEOUT_EN to exercise
// the forced-release path.
module tb_fsm_job_arbiter;

  localparam int N_REQ = 4;
`ifdef FSM_ARB_TIMEOUT_EN
  localparam int EXP_ERR = 1;
`else
  localparam int EXP_ERR = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [3:0] gnt;
  logic [1:0] eng_state = 2'b00;
  logic       eng_ack = 1'b0;
  logic       eng_start, eng_init, cpl, busy, err;
  logic [1:0] cpl_id, cpl_status;

  always #5 clk = ~clk;

  fsm_job_arbiter #(.N_REQ(N_REQ), .TIMEOUT(15)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .gnt        (gnt),
    .eng_state  (eng_state),
    .eng_ack    (eng_ack),
    .eng_start  (eng_start),
    .eng_init   (eng_init),
    .cpl        (cpl),
    .cpl_id     (cpl_id),
    .cpl_status (cpl_status),
    .busy       (busy),
    .err        (err)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int exp_gnt_q[$];   // expected winner index per grant
  int exp_cpl_q[$];   // expected id*4 + status per completion
  int err_seen = 0;

  // engine model state
  logic [1:0] e_state = 2'b00;
  int         e_cnt = 0;
  int         run_len = 3;
  bit         ack_mode = 1'b0;
  logic       p_start, p_init, p_busy;
  logic [3:0] p_gnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: engine registers the arbiter outputs of the previous cycle,
  // then outputs are sampled 1 time unit after the edge.
  task automatic step();
    int e;
    int g;
    p_start = eng_start;
    p_init  = eng_init;
    p_gnt   = gnt;
    p_busy  = busy;
    @(posedge clk);
    #1;
    if (rst) begin
      e_state = 2'b00;
      e_cnt   = 0;
    end else begin
      case (e_state)
        2'b00: if (p_start) begin e_state = 2'b01; e_cnt = run_len; end
        2'b01: if (e_cnt == 0) e_state = ack_mode ? 2'b11 : 2'b10; else e_cnt--;
        2'b10: e_state = 2'b00;
        2'b11: if (p_init) e_state = 2'b00;
        default: e_state = 2'b00;
      endcase
    end
    eng_state = e_state;
    eng_ack   = (e_state == 2'b11);
    if (err) err_seen++;
    if (cpl) begin
      if (exp_cpl_q.size() == 0) begin
        check("cpl_unexpected", 32'(cpl), 32'd0);
      end else begin
        e = exp_cpl_q.pop_front();
        check("cpl_id", 32'(cpl_id), 32'(e / 4));
        check("cpl_status", 32'(cpl_status), 32'(e % 4));
      end
    end
    if ((gnt != 4'b0000) && (p_gnt == 4'b0000)) begin
      check("gnt_onehot", 32'($onehot(gnt)), 32'd1);
      check("gnt_idle_gap", 32'(p_busy), 32'd0);
      if (exp_gnt_q.size() == 0) begin
        check("gnt_unexpected", 32'(gnt), 32'd0);
      end else begin
        g = exp_gnt_q.pop_front();
        check("gnt", 32'(gnt), 32'(1 << g));
      end
    end
  endtask

  // which: 0 eng_start, 1 eng_ack, 2 cpl, 3 err
  task automatic wait_for(input int which, input int budget, input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      step();
      case (which)
        0: seen = eng_start;
        1: seen = eng_ack;
        2: seen = cpl;
        3: seen = err;
        default: seen = 1'b1;
      endcase
    end
    check({tag, "_timeout"}, 32'(seen), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    // reset state
    step();
    step();
    check("rst_outputs", 32'({gnt, eng_start, eng_init, cpl, cpl_id, cpl_status, busy, err}), 32'd0);
    rst = 1'b0;

    // T1: single requester, done-path
    req = 4'b0001; ack_mode = 1'b0; run_len = 3;
    exp_gnt_q.push_back(0); exp_cpl_q.push_back(0 * 4 + 1);
    step();
    check("t1_gnt_c1", 32'(gnt), 32'h1);
    check("t1_start_c1", 32'(eng_start), 32'd0);
    check("t1_busy_c1", 32'(busy), 32'd1);
    step();
    check("t1_start_c2", 32'(eng_start), 32'd1);
    step();
    check("t1_start_c3", 32'(eng_start), 32'd0);
    wait_for(2, 50, "t1_cpl");
    req = 4'b0000;
    check("t1_idle_at_cpl", 32'({gnt, busy}), 32'd0);

    // T2: all requesting, strict rotation from a fresh pointer
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_gnt_q.push_back(k % 4);
      exp_cpl_q.push_back((k % 4) * 4 + 1);
    end
    for (int k = 0; k < 5; k++) wait_for(2, 50, "t2_cpl");
    req = 4'b0000;
    check("t2_gnt_q_empty", 32'(exp_gnt_q.size()), 32'd0);

    // T3: ack-path, hold until req drops, then release
    req = 4'b0100; ack_mode = 1'b1;
    exp_gnt_q.push_back(2); exp_cpl_q.push_back(2 * 4 + 2);
    wait_for(1, 50, "t3_ack");
    for (int k = 0; k < 5; k++) step();
    check("t3_hold_gnt", 32'(gnt), 32'h4);
    check("t3_hold_init", 32'(eng_init), 32'd0);
    check("t3_hold_busy", 32'(busy), 32'd1);
    req = 4'b0000;
    step();
    check("t3_init_next", 32'(eng_init), 32'd1);
    wait_for(2, 50, "t3_cpl");
    check("t3_init_off", 32'(eng_init), 32'd0);

    // T4: ack-path with req held
    do_reset();
    err_seen = 0;
    req = 4'b0010; ack_mode = 1'b1;
    exp_gnt_q.push_back(1);
`ifdef FSM_ARB_TIMEOUT_EN
    exp_cpl_q.push_back(1 * 4 + 3);
    wait_for(1, 50, "t4_ack");
    wait_for(3, 60, "t4_err");
    check("t4_init_at_err", 32'(eng_init), 32'd1);
    wait_for(2, 50, "t4_cpl");
    req = 4'b0000;
`else
    for (int k = 0; k < 100; k++) step();
    check("t4_still_gnt", 32'(gnt), 32'h2);
    check("t4_still_busy", 32'(busy), 32'd1);
    check("t4_no_init", 32'(eng_init), 32'd0);
    exp_cpl_q.push_back(1 * 4 + 2);
    req = 4'b0000;
    wait_for(2, 50, "t4_cpl");
`endif
    check("t4_err_count", 32'(err_seen), 32'(EXP_ERR));

    // T5: reset during WAIT aborts; pointer returns to N_REQ-1
    req = 4'b0100; ack_mode = 1'b0; run_len = 10;
    exp_gnt_q.push_back(2);
    wait_for(0, 20, "t5_start");
    step();
    step();
    rst = 1'b1;
    #1;
    check("t5_rst_async", 32'({gnt, eng_start, eng_init, cpl, cpl_id, cpl_status, busy}), 32'd0);
    step();
    step();
    check("t5_rst_hold", 32'({gnt, cpl, busy}), 32'd0);
    req = 4'b0110; run_len = 3;
    rst = 1'b0;
    exp_gnt_q.push_back(1); exp_cpl_q.push_back(1 * 4 + 1);
    wait_for(2, 50, "t5_cpl");
    req = 4'b0000;

    // T6: granted req drops during WAIT, job still completes
    req = 4'b0010; ack_mode = 1'b0; run_len = 4;
    exp_gnt_q.push_back(1); exp_cpl_q.push_back(1 * 4 + 1);
    wait_for(0, 20, "t6_start");
    step();
    step();
    req = 4'b0000;
    wait_for(2, 50, "t6_cpl");
    for (int k = 0; k < 5; k++) step();
    check("t6_no_regrant", 32'({gnt, busy}), 32'd0);

    check("end_gnt_q_empty", 32'(exp_gnt_q.size()), 32'd0);
    check("end_cpl_q_empty", 32'(exp_cpl_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
